// File: rtl/hist_frame_ctrl_if.sv
// Valid/ready stream handshake used for the XDS input, the datapath feed and
// the threshold output of the histogram frame sequencer.
interface hist_frame_ctrl_if;
  logic valid;
  logic ready;

  modport master (output valid, input ready);
  modport slave  (input valid, output ready);
endinterface

// File: rtl/hist_frame_ctrl.sv
// Frame sequencer for the depth-histogram threshold datapath: clears the
// histogram, gates width*height pixels through with coordinates, drains,
// triggers thresholding and holds the output handshake.
module hist_frame_ctrl #(
  parameter int unsigned P_WIDTH_BIT    = 10,
  parameter int unsigned P_HEIGHT_BIT   = 10,
  parameter int unsigned P_CLR_CYCLES   = 256,
  parameter int unsigned P_FLUSH_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [P_WIDTH_BIT-1:0]  width,
  input  logic [P_HEIGHT_BIT-1:0] height,
  input  logic                    start,
  output logic                    busy,
  output logic                    frame_start,
  output logic                    frame_finish,
  hist_frame_ctrl_if.slave        src,
  hist_frame_ctrl_if.master       dp,
  output logic [P_WIDTH_BIT-1:0]  pix_x,
  output logic [P_HEIGHT_BIT-1:0] pix_y,
  output logic                    pix_last,
  output logic                    hist_clr,
  output logic                    th_start,
  input  logic                    th_done,
  hist_frame_ctrl_if.master       xds_out
);

  localparam int unsigned CLR_W   = $clog2(P_CLR_CYCLES + 1);
  localparam int unsigned FLUSH_W = $clog2(P_FLUSH_CYCLES + 1);
  localparam logic [CLR_W-1:0]   CLR_LAST   = CLR_W'(P_CLR_CYCLES - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(P_FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_FLUSH,
    S_THRESH,
    S_OUTPUT
  } state_t;

  state_t state_q, state_d;

  logic [P_WIDTH_BIT-1:0]  w_q;
  logic [P_HEIGHT_BIT-1:0] h_q;
  logic [P_WIDTH_BIT-1:0]  x_q;
  logic [P_HEIGHT_BIT-1:0] y_q;
  logic [CLR_W-1:0]        clr_cnt_q;
  logic [FLUSH_W-1:0]      flush_cnt_q;
  logic                    th_first_q;
  logic                    out_valid_q;
  logic                    finish_q;

  logic in_accum;
  logic pix_hs;
  logic x_end;
  logic y_end;
  logic last_pix;
  logic zero_dim;
  logic clr_done;
  logic flush_done;
  logic out_hs;

  always_comb begin
    in_accum   = (state_q == S_ACCUM);
    pix_hs     = in_accum & src.valid & dp.ready;
    x_end      = (x_q == (w_q - P_WIDTH_BIT'(1)));
    y_end      = (y_q == (h_q - P_HEIGHT_BIT'(1)));
    last_pix   = in_accum & x_end & y_end;
    zero_dim   = (w_q == '0) | (h_q == '0);
    clr_done   = (clr_cnt_q == CLR_LAST);
    flush_done = (flush_cnt_q == FLUSH_LAST);
    out_hs     = (state_q == S_OUTPUT) & out_valid_q & xds_out.ready;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_CLEAR;
      // An empty frame skips pixel acceptance but still drains and thresholds
      S_CLEAR:  if (clr_done) state_d = zero_dim ? S_FLUSH : S_ACCUM;
      S_ACCUM:  if (pix_hs && last_pix) state_d = S_FLUSH;
      S_FLUSH:  if (flush_done) state_d = S_THRESH;
      S_THRESH: if (th_done) state_d = S_OUTPUT;
      S_OUTPUT: if (out_hs) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    hist_clr      = (state_q == S_CLEAR);
    frame_start   = (state_q == S_CLEAR) && (clr_cnt_q == '0);
    frame_finish  = finish_q;
    th_start      = (state_q == S_THRESH) && th_first_q;
    dp.valid      = in_accum & src.valid;
    src.ready     = in_accum & dp.ready;
    xds_out.valid = out_valid_q;
    pix_x         = x_q;
    pix_y         = y_q;
    pix_last      = last_pix;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_q <= '0;
      h_q <= '0;
      x_q <= '0;
      y_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        w_q <= width;
        h_q <= height;
        x_q <= '0;
        y_q <= '0;
      end
    end else if (pix_hs) begin
      if (last_pix) begin
        x_q <= '0;
        y_q <= '0;
      end else if (x_end) begin
        x_q <= '0;
        y_q <= y_q + P_HEIGHT_BIT'(1);
      end else begin
        x_q <= x_q + P_WIDTH_BIT'(1);
      end
    end
  end

  // Counters run only inside their own state and sit at zero otherwise,
  // so every entry into CLEAR/FLUSH starts a fresh count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clr_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (state_q == S_CLEAR && !clr_done) begin
        clr_cnt_q <= clr_cnt_q + CLR_W'(1);
      end else begin
        clr_cnt_q <= '0;
      end
      if (state_q == S_FLUSH && !flush_done) begin
        flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
      end else begin
        flush_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      th_first_q  <= 1'b0;
      out_valid_q <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      th_first_q  <= (state_d == S_THRESH) && (state_q != S_THRESH);
      out_valid_q <= (state_d == S_OUTPUT);
      finish_q    <= out_hs;
    end
  end

endmodule

// File: tb/tb_hist_frame_ctrl.sv
// Scoreboard bench for hist_frame_ctrl: expected pixels are queued per frame,
// a negedge monitor checks the stream and protocol, frame timing is checked
// against cycle formulas after each frame.
module tb_hist_frame_ctrl;
  localparam int WB    = 4;
  localparam int HB    = 4;
  localparam int NCLR  = 4;
  localparam int NFL   = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [WB-1:0] width = '0;
  logic [HB-1:0] height = '0;
  logic          busy, frame_start, frame_finish;
  logic [WB-1:0] pix_x;
  logic [HB-1:0] pix_y;
  logic          pix_last, hist_clr, th_start;
  logic          th_done;

  hist_frame_ctrl_if src_if();
  hist_frame_ctrl_if dp_if();
  hist_frame_ctrl_if xo_if();

  hist_frame_ctrl #(
    .P_WIDTH_BIT(WB),
    .P_HEIGHT_BIT(HB),
    .P_CLR_CYCLES(NCLR),
    .P_FLUSH_CYCLES(NFL)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .width(width),
    .height(height),
    .start(start),
    .busy(busy),
    .frame_start(frame_start),
    .frame_finish(frame_finish),
    .src(src_if),
    .dp(dp_if),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_last(pix_last),
    .hist_clr(hist_clr),
    .th_start(th_start),
    .th_done(th_done),
    .xds_out(xo_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int x;
    int y;
    bit last;
  } pix_t;
  pix_t exp_q[$];

  task automatic push_frame(input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        exp_q.push_back('{x, y, (x == w - 1) && (y == h - 1)});
  endtask

  // Stimulus modes: vmode random src_valid/dp_ready, tmode random th_done,
  // omode holds xds_out ready low for the first 5 valid cycles.
  int vmode = 0;
  int tmode = 0;
  int omode = 0;

  initial begin
    int vcnt;
    vcnt = 0;
    src_if.valid = 1'b0;
    dp_if.ready  = 1'b0;
    xo_if.ready  = 1'b0;
    th_done      = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      src_if.valid = (vmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      dp_if.ready  = (vmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      th_done      = (tmode != 0) ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (xo_if.valid) vcnt++;
      else vcnt = 0;
      xo_if.ready = (omode != 0) ? (vcnt > 5) : 1'b1;
    end
  end

  // Monitor state and event log
  int fs_cnt = 0, fs_cyc = 0, clr_cnt = 0, clr_rise = 0;
  int hs_cnt = 0, hs_first = 0, hs_last = 0, vis_cnt = 0;
  int th_cnt = 0, th_cyc = 0, thd_cyc = 0, xv_first = 0;
  int oh_cyc = 0, ff_cnt = 0, ff_cyc = 0;
  bit prev_clr = 0, prev_xv = 0, prev_xr = 0, prev_oh = 0;
  bit in_th = 0, new_frame = 0;

  always @(negedge clk) begin
    bit vis, hs;
    if (!rstn) begin
      prev_clr = 0; prev_xv = 0; prev_xr = 0; prev_oh = 0;
      in_th = 0; new_frame = 0;
    end else begin
      vis = src_if.ready | dp_if.valid;
      hs  = dp_if.valid & dp_if.ready;
      chk("hs_agree", int'(src_if.valid & src_if.ready), int'(hs));
      chk("src_ready_without_dp_ready", int'(src_if.ready & ~dp_if.ready), 0);
      chk("dp_valid_without_src_valid", int'(dp_if.valid & ~src_if.valid), 0);
      if (!busy || hist_clr) begin
        chk("stream_open_outside_accum", int'(vis), 0);
        chk("pix_last_outside_accum", int'(pix_last), 0);
      end
      if (vis) begin
        vis_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_stream", 1, 0);
        end else begin
          chk("pix_x", int'(pix_x), exp_q[0].x);
          chk("pix_y", int'(pix_y), exp_q[0].y);
          if (hs) begin
            chk("pix_last", int'(pix_last), int'(exp_q[0].last));
            void'(exp_q.pop_front());
            hs_cnt++;
            if (new_frame) hs_first = cyc;
            new_frame = 0;
            hs_last = cyc;
          end
        end
      end
      if (frame_start) begin
        fs_cnt++;
        fs_cyc = cyc;
        new_frame = 1;
      end
      if (hist_clr) clr_cnt++;
      if (hist_clr && !prev_clr) clr_rise = cyc;
      prev_clr = hist_clr;
      if (th_start) begin
        th_cnt++;
        th_cyc = cyc;
        in_th = 1;
      end
      if (in_th && th_done) begin
        thd_cyc = cyc;
        in_th = 0;
      end
      if (xo_if.valid && !prev_xv) xv_first = cyc;
      if (prev_xv && !prev_xr) chk("xds_valid_held", int'(xo_if.valid), 1);
      chk("xds_valid_while_idle", int'(xo_if.valid & ~busy), 0);
      chk("finish_after_out_hs", int'(frame_finish), int'(prev_oh));
      if (frame_finish) begin
        ff_cnt++;
        ff_cyc = cyc;
      end
      prev_oh = xo_if.valid & xo_if.ready;
      if (prev_oh) oh_cyc = cyc;
      prev_xv = xo_if.valid;
      prev_xr = xo_if.ready;
    end
  end

  task automatic chk_outputs_zero();
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_frame_finish", int'(frame_finish), 0);
    chk("rst_hist_clr", int'(hist_clr), 0);
    chk("rst_th_start", int'(th_start), 0);
    chk("rst_pix_last", int'(pix_last), 0);
    chk("rst_pix_x", int'(pix_x), 0);
    chk("rst_pix_y", int'(pix_y), 0);
    chk("rst_src_ready", int'(src_if.ready), 0);
    chk("rst_dp_valid", int'(dp_if.valid), 0);
    chk("rst_xds_valid", int'(xo_if.valid), 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic run_frame(input int w, input int h);
    int fs0, clr0, hs0, th0, ff0, vis0, t0, n;
    wait_idle();
    fs0 = fs_cnt; clr0 = clr_cnt; hs0 = hs_cnt;
    th0 = th_cnt; ff0 = ff_cnt; vis0 = vis_cnt;
    push_frame(w, h);
    width  = WB'(w);
    height = HB'(h);
    start  = 1'b1;
    t0     = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (ff_cnt == ff0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_done", ff_cnt - ff0, 1);
    chk("frame_start_count", fs_cnt - fs0, 1);
    chk("frame_start_cycle", fs_cyc, t0 + 1);
    chk("hist_clr_cycles", clr_cnt - clr0, NCLR);
    chk("hist_clr_first", clr_rise, t0 + 1);
    chk("handshakes", hs_cnt - hs0, w * h);
    chk("queue_drained", exp_q.size(), 0);
    chk("th_start_count", th_cnt - th0, 1);
    if (w * h == 0) begin
      chk("zero_dim_stream", vis_cnt - vis0, 0);
      chk("th_start_cycle", th_cyc, t0 + NCLR + NFL + 1);
    end else begin
      chk("th_start_cycle", th_cyc, hs_last + NFL + 1);
    end
    if (vmode == 0 && w * h > 0) begin
      chk("first_hs_cycle", hs_first, t0 + NCLR + 1);
      chk("last_hs_cycle", hs_last, t0 + NCLR + w * h);
    end
    chk("xds_valid_cycle", xv_first, thd_cyc + 1);
    chk("frame_finish_cycle", ff_cyc, oh_cyc + 1);
    if (omode != 0) chk("out_ready_wait", oh_cyc - xv_first, 5);
  endtask

  initial begin
    int ff0, fs0, hs0, n;
    #2;
    chk_outputs_zero();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Nominal 4x2 frame with full-rate stream and immediate th_done
    run_frame(4, 2);

    // Backpressure on both sides of the stream
    vmode = 1;
    run_frame(4, 2);
    run_frame(4, 2);
    vmode = 0;

    // Zero-dimension and boundary frames
    run_frame(0, 5);
    run_frame(3, 0);
    run_frame(1, 1);
    run_frame(15, 15);

    // Output held off for 5 valid cycles
    omode = 1;
    run_frame(3, 2);
    omode = 0;

    // Start held high across a frame: one frame_start, back-to-back accept
    wait_idle();
    ff0 = ff_cnt; fs0 = fs_cnt;
    push_frame(2, 2);
    push_frame(2, 2);
    width = WB'(2); height = HB'(2); start = 1'b1;
    n = 0;
    while (ff_cnt == ff0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held_first_finish", ff_cnt - ff0, 1);
    chk("held_single_start", fs_cnt - fs0, 1);
    @(posedge clk); #1;
    chk("held_restart_count", fs_cnt - fs0, 2);
    chk("held_restart_cycle", fs_cyc, ff_cyc + 1);
    start = 1'b0;
    n = 0;
    while (ff_cnt < ff0 + 2 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held_second_finish", ff_cnt - ff0, 2);
    chk("held_queue_drained", exp_q.size(), 0);
    chk("held_no_third_start", fs_cnt - fs0, 2);

    // Reset in the middle of ACCUM at pixel (2,1)
    wait_idle();
    hs0 = hs_cnt; ff0 = ff_cnt;
    push_frame(4, 2);
    width = WB'(4); height = HB'(2); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (hs_cnt - hs0 < 6 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reset_point_hs", hs_cnt - hs0, 6);
    chk("reset_point_x", int'(pix_x), 2);
    chk("reset_point_y", int'(pix_y), 1);
    rstn = 1'b0;
    #1;
    chk_outputs_zero();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("reset_no_finish", ff_cnt - ff0, 0);
    chk("reset_idle", int'(busy), 0);
    run_frame(4, 2);

    // Randomized frames and handshakes
    for (int i = 0; i < 6; i++) begin
      vmode = 1;
      tmode = int'($urandom_range(0, 1));
      omode = int'($urandom_range(0, 1));
      run_frame(int'($urandom_range(1, 5)), int'($urandom_range(1, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hist_frame_ctrl.md
# hist_frame_ctrl

Frame sequencer for the depth-histogram threshold datapath. It latches frame geometry and gates the XDS input stream into the datapath for exactly width×height pixels, tagging each pixel with its coordinates. Around that it clears the histogram, drains the pipeline, triggers threshold computation and holds the XDS output handshake. It sits between the depth source and the histogram/threshold datapath, and owns frame_start/frame_finish.

## Interface
- P_WIDTH_BIT, 10, width of width input and x counter
- P_HEIGHT_BIT, 10, width of height input and y counter
- P_CLR_CYCLES, 256, histogram clear cycles (= histogram bin count), must be ≥1
- P_FLUSH_CYCLES, 4, datapath pipeline drain cycles after last pixel, must be ≥1

Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rstn`).
- clk  in  1  clock
- rstn  in  1  async active-low reset
- width  in  P_WIDTH_BIT  frame width, sampled on accepted start
- height  in  P_HEIGHT_BIT  frame height, sampled on accepted start
- start  in  1  frame request, level-sampled in IDLE only
- busy  out  1  state != IDLE
- frame_start  out  1  one-cycle pulse, first CLEAR cycle
- frame_finish  out  1  one-cycle pulse, first IDLE cycle after output handshake
- src_valid  in  1  upstream XDS valid
- src_ready  out  1  upstream XDS ready
- dp_valid  out  1  datapath input valid
- dp_ready  in  1  datapath input ready
- pix_x  out  P_WIDTH_BIT  column of current pixel
- pix_y  out  P_HEIGHT_BIT  row of current pixel
- pix_last  out  1  current pixel is last of frame
- hist_clr  out  1  histogram clear enable
- th_start  out  1  one-cycle threshold computation trigger
- th_done  in  1  threshold computation complete
- xds_out_valid  out  1  thresholds valid to downstream
- xds_out_ready  in  1  downstream ready

## Operation
- States: IDLE, CLEAR, ACCUM, FLUSH, THRESH, OUTPUT.
- IDLE: start=1 → latch width/height, clear x/y and counters → CLEAR.
- CLEAR: hist_clr=1 for exactly P_CLR_CYCLES cycles.
  - After the last clear cycle → ACCUM.
  - If latched width==0 or height==0 → FLUSH instead; no pixels are accepted.
- ACCUM:
  - dp_valid = src_valid, src_ready = dp_ready (combinational).
  - Both are forced 0 in every other state.
- Handshake = src_valid & dp_ready in ACCUM.
  - On handshake: x increments; x==w-1 → x=0, y increments.
- pix_last = (x==w-1)&&(y==h-1), gated to ACCUM.
- Handshake with pix_last=1 → FLUSH. Exactly w×h handshakes per frame.
- FLUSH: P_FLUSH_CYCLES cycles → THRESH.
- THRESH: th_start=1 in first THRESH cycle only. th_done sampled every THRESH cycle, including the first; th_done=1 → OUTPUT.
- OUTPUT: xds_out_valid=1 (registered). xds_out_valid & xds_out_ready → IDLE; valid deasserts next cycle.
- start outside IDLE is ignored; no queuing.
- th_done outside THRESH is ignored.
- pix_x/pix_y hold during stalls and are valid only in ACCUM.

## Timing
- Reset (async, immediate): state=IDLE; all outputs 0; x/y/counters 0. Reset mid-frame aborts the frame with no frame_finish.
- start sampled high at cycle T (IDLE):
  - frame_start and hist_clr at T+1.
  - hist_clr high T+1..T+P_CLR_CYCLES.
  - First possible handshake T+P_CLR_CYCLES+1.
- Last handshake at cycle L:
  - FLUSH cycles L+1..L+P_FLUSH_CYCLES.
  - th_start at L+P_FLUSH_CYCLES+1.
- th_done at cycle D → xds_out_valid=1 from D+1.
- Output handshake at cycle O:
  - xds_out_valid=0, busy=0 and frame_finish=1 at O+1.
  - start at O+1 is accepted.
- Zero-dimension frame: FLUSH begins the cycle after the last clear cycle.
- Counter widths: clear counter $clog2(P_CLR_CYCLES+1), flush counter $clog2(P_FLUSH_CYCLES+1).
- Max frame is (2^P_WIDTH_BIT−1)×(2^P_HEIGHT_BIT−1).

## Test plan
- Nominal 4×2 frame, P_CLR_CYCLES=4, P_FLUSH_CYCLES=2, src_valid=dp_ready=1, start at T=0, th_done at first THRESH cycle, xds_out_ready=1 → frame_start T1; hist_clr T1–T4; handshakes T5–T12 with (x,y) (0,0)…(3,1); pix_last only T12; th_start T15; xds_out_valid T16; frame_finish T17.
- Backpressure, 4×2 frame, src_valid and dp_ready driven by independent random patterns → exactly 8 handshakes; pix_x/pix_y stable during stalls; src_ready never 1 outside ACCUM.
- Start handling: start held high for a whole frame → exactly one frame_start, and a new frame_start at frame_finish+1 (back-to-back accept).
- width=0, height=5 → no src_ready/dp_valid ever; th_start at T+P_CLR_CYCLES+P_FLUSH_CYCLES+1; normal output handshake; frame_finish.
- rstn low mid-ACCUM at pixel (2,1) → all outputs 0 immediately, no frame_finish; next frame restarts at (0,0) with full clear.
- xds_out_ready low for 5 cycles in OUTPUT → xds_out_valid held high throughout; frame_finish only one cycle after the ready-high handshake.
